// File: rtl/AHB_PKG.sv
// rtl/AHB_PKG.sv - AHB-Lite transfer and burst type definitions
package AHB_PKG;

  typedef logic [2:0] burst_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_t;

endpackage

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - N-master AHB-Lite arbiter sharing one slave port
// Ownership moves only when the owner is IDLE with HREADY high, so bursts are never split.
module ahb_arbiter #(
  parameter int N_MASTERS    = 2,
  parameter int RR           = 0,
  parameter int STARVE_LIMIT = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           M_HADDR  [N_MASTERS],
  input  AHB_PKG::burst_t       M_HBURST [N_MASTERS],
  input  AHB_PKG::trans_t       M_HTRANS [N_MASTERS],
  input  logic [N_MASTERS-1:0]  M_HWRITE,
  input  logic [31:0]           M_HWDATA [N_MASTERS],
  output logic [31:0]           M_HRDATA [N_MASTERS],
  output logic [N_MASTERS-1:0]  M_HREADY,
  output logic [N_MASTERS-1:0]  M_HRESP,
  output logic [31:0]           HADDR,
  output AHB_PKG::burst_t       HBURST,
  output AHB_PKG::trans_t       HTRANS,
  output logic                  HWRITE,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic [N_MASTERS-1:0]  GRANT_OUT,
  output logic [N_MASTERS-1:0]  STARVE_OUT
);
  import AHB_PKG::*;

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        d_owner_q, d_owner_d;
  logic                 d_valid_q, d_valid_d;
  logic [CW-1:0]        wait_cnt_q [N_MASTERS];
  logic [CW-1:0]        wait_cnt_d [N_MASTERS];

  trans_t               owner_trans;
  logic [N_MASTERS-1:0] is_owner;
  logic [N_MASTERS-1:0] req;
  logic [IW-1:0]        winner;
  logic                 win_found;
  int                   cand;

  assign owner_trans = M_HTRANS[owner_q];

  always_comb begin
    HADDR  = M_HADDR[owner_q];
    HBURST = M_HBURST[owner_q];
    HWRITE = M_HWRITE[owner_q];
    HTRANS = HRESET ? IDLE : owner_trans;
    HWDATA = M_HWDATA[d_owner_q];
  end

  // Non-owners that present anything but IDLE are held off and must keep their address.
  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      is_owner[m] = (owner_q == IW'(m));
      req[m]      = !is_owner[m] && (M_HTRANS[m] == NONSEQ);
      M_HRDATA[m] = HRDATA;
      if (HRESET) begin
        M_HREADY[m] = 1'b1;
      end else if (is_owner[m]) begin
        M_HREADY[m] = HREADY;
      end else begin
        M_HREADY[m] = (M_HTRANS[m] == IDLE);
      end
      M_HRESP[m]    = !HRESET && HRESP && d_valid_q && (d_owner_q == IW'(m));
      GRANT_OUT[m]  = HRESET ? (m == 0) : is_owner[m];
      STARVE_OUT[m] = !HRESET && (wait_cnt_q[m] >= LIMIT);
    end
  end

  // Scans run backwards so the last hit is the preferred one.
  always_comb begin
    winner    = owner_q;
    win_found = 1'b0;
    cand      = 0;
    if (RR == 0) begin
      for (int m = N_MASTERS - 1; m >= 0; m--) begin
        if (req[m]) begin
          winner    = IW'(m);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int j = N_MASTERS; j >= 1; j--) begin
        cand = int'(last_q) + j;
        if (cand >= N_MASTERS) begin
          cand = cand - N_MASTERS;
        end
        if (req[cand]) begin
          winner    = IW'(cand);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    d_owner_d = d_owner_q;
    d_valid_d = d_valid_q;
    if (HREADY) begin
      d_owner_d = owner_q;
      d_valid_d = (owner_trans == NONSEQ) || (owner_trans == SEQ);
      if ((owner_trans == IDLE) && win_found) begin
        owner_d = winner;
        last_d  = winner;
      end
    end
    for (int m = 0; m < N_MASTERS; m++) begin
      wait_cnt_d[m] = wait_cnt_q[m];
      if (is_owner[m] || (M_HTRANS[m] == IDLE)) begin
        wait_cnt_d[m] = '0;
      end else if (!M_HREADY[m] && (wait_cnt_q[m] != CNT_MAX)) begin
        wait_cnt_d[m] = wait_cnt_q[m] + CW'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q   <= '0;
      last_q    <= '0;
      d_owner_q <= '0;
      d_valid_q <= 1'b0;
      for (int m = 0; m < N_MASTERS; m++) begin
        wait_cnt_q[m] <= '0;
      end
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      d_owner_q  <= d_owner_d;
      d_valid_q  <= d_valid_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed bench for ahb_arbiter with a behavioural ownership model
module tb_ahb_arbiter;
  import AHB_PKG::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance 0: two masters, fixed priority, limit 255
  logic        rst0;
  logic [31:0] a0 [2];
  burst_t      b0 [2];
  trans_t      t0 [2];
  logic [1:0]  w0;
  logic [31:0] wd0 [2];
  logic [31:0] mrd0 [2];
  logic [1:0]  rdy0, resp0, gnt0, stv0;
  logic [31:0] haddr0, hwdata0, hrdata0;
  burst_t      hburst0;
  trans_t      htrans0;
  logic        hwrite0, hready0, hresp0;

  // instance 1: three masters, round-robin, limit 3
  logic        rst1;
  logic [31:0] a1 [3];
  burst_t      b1 [3];
  trans_t      t1 [3];
  logic [2:0]  w1;
  logic [31:0] wd1 [3];
  logic [31:0] mrd1 [3];
  logic [2:0]  rdy1, resp1, gnt1, stv1;
  logic [31:0] haddr1, hwdata1, hrdata1;
  burst_t      hburst1;
  trans_t      htrans1;
  logic        hwrite1, hready1, hresp1;

  ahb_arbiter #(.N_MASTERS(2), .RR(0), .STARVE_LIMIT(255)) dut0 (
    .HCLK(clk), .HRESET(rst0), .M_HADDR(a0), .M_HBURST(b0), .M_HTRANS(t0),
    .M_HWRITE(w0), .M_HWDATA(wd0), .M_HRDATA(mrd0), .M_HREADY(rdy0), .M_HRESP(resp0),
    .HADDR(haddr0), .HBURST(hburst0), .HTRANS(htrans0), .HWRITE(hwrite0), .HWDATA(hwdata0),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0), .GRANT_OUT(gnt0), .STARVE_OUT(stv0)
  );

  ahb_arbiter #(.N_MASTERS(3), .RR(1), .STARVE_LIMIT(3)) dut1 (
    .HCLK(clk), .HRESET(rst1), .M_HADDR(a1), .M_HBURST(b1), .M_HTRANS(t1),
    .M_HWRITE(w1), .M_HWDATA(wd1), .M_HRDATA(mrd1), .M_HREADY(rdy1), .M_HRESP(resp1),
    .HADDR(haddr1), .HBURST(hburst1), .HTRANS(htrans1), .HWRITE(hwrite1), .HWDATA(hwdata1),
    .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1), .GRANT_OUT(gnt1), .STARVE_OUT(stv1)
  );

  function automatic int nof(input int k);   return (k == 0) ? 2 : 3;   endfunction
  function automatic int limof(input int k); return (k == 0) ? 255 : 3; endfunction
  function automatic bit rst(input int k);   return (k == 0) ? rst0 : rst1; endfunction
  function automatic bit rdy_in(input int k); return (k == 0) ? hready0 : hready1; endfunction
  function automatic bit rsp_in(input int k); return (k == 0) ? hresp0 : hresp1; endfunction
  function automatic int tr(input int k, input int m);
    if (k == 0) return int'(t0[m]);
    return int'(t1[m]);
  endfunction
  function automatic logic [31:0] fa(input int k, input int m);
    return (k == 0) ? a0[m] : a1[m];
  endfunction
  function automatic logic [31:0] fwd(input int k, input int m);
    return (k == 0) ? wd0[m] : wd1[m];
  endfunction
  function automatic logic [31:0] fb(input int k, input int m);
    return (k == 0) ? 32'(b0[m]) : 32'(b1[m]);
  endfunction
  function automatic logic [31:0] fw(input int k, input int m);
    return (k == 0) ? 32'(w0[m]) : 32'(w1[m]);
  endfunction

  // Model: who owns the bus, who owns the data phase, and how long each master has waited.
  int own [2];
  int lst [2];
  int dow [2];
  int dv  [2];
  int wc  [2][3];
  bit armed [2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int n, ot, win, c;
    n = nof(k);
    if (rst(k)) begin
      own[k] = 0; lst[k] = 0; dow[k] = 0; dv[k] = 0;
      for (int m = 0; m < 3; m++) wc[k][m] = 0;
      armed[k] = 1'b1;
      return;
    end
    if (!armed[k]) return;
    for (int m = 0; m < n; m++) begin
      if (tr(k, m) == 0 || m == own[k]) wc[k][m] = 0;
      else if (wc[k][m] < limof(k)) wc[k][m] = wc[k][m] + 1;
    end
    if (rdy_in(k)) begin
      ot = tr(k, own[k]);
      dow[k] = own[k];
      dv[k] = (ot >= 2) ? 1 : 0;
      if (ot == 0) begin
        win = -1;
        for (int j = 1; j <= n; j++) begin
          c = (k == 1) ? (lst[k] + j) % n : j - 1;
          if (win < 0 && c != own[k] && tr(k, c) == 2) win = c;
        end
        if (win >= 0) begin
          own[k] = win;
          lst[k] = win;
        end
      end
    end
  endtask

  task automatic compare(input int k);
    int n, eg, er, ep, es;
    bit r;
    string p;
    logic [31:0] g, rd, rs, sv, ht, ha, hw, hb, hwr, hrd;
    if (!armed[k]) return;
    n = nof(k);
    r = rst(k);
    p = (k == 0) ? "i0" : "i1";
    if (k == 0) begin
      g = 32'(gnt0); rd = 32'(rdy0); rs = 32'(resp0); sv = 32'(stv0); ht = 32'(htrans0);
      ha = haddr0; hw = hwdata0; hb = 32'(hburst0); hwr = 32'(hwrite0); hrd = hrdata0;
    end else begin
      g = 32'(gnt1); rd = 32'(rdy1); rs = 32'(resp1); sv = 32'(stv1); ht = 32'(htrans1);
      ha = haddr1; hw = hwdata1; hb = 32'(hburst1); hwr = 32'(hwrite1); hrd = hrdata1;
    end
    eg = 0; er = 0; ep = 0; es = 0;
    for (int m = 0; m < n; m++) begin
      if (r ? (m == 0) : (m == own[k])) eg |= (1 << m);
      if (r || ((m == own[k]) ? rdy_in(k) : (tr(k, m) == 0))) er |= (1 << m);
      if (!r && rsp_in(k) && dv[k] != 0 && dow[k] == m) ep |= (1 << m);
      if (!r && wc[k][m] >= limof(k)) es |= (1 << m);
      chk({p, ".m_hrdata"}, (k == 0) ? mrd0[m] : mrd1[m], hrd);
    end
    chk({p, ".grant"}, g, 32'(eg));
    chk({p, ".m_hready"}, rd, 32'(er));
    chk({p, ".m_hresp"}, rs, 32'(ep));
    chk({p, ".starve"}, sv, 32'(es));
    chk({p, ".htrans"}, ht, r ? 32'd0 : 32'(tr(k, own[k])));
    if (!r) begin
      chk({p, ".haddr"}, ha, fa(k, own[k]));
      chk({p, ".hburst"}, hb, fb(k, own[k]));
      chk({p, ".hwrite"}, hwr, fw(k, own[k]));
      chk({p, ".hwdata"}, hw, fwd(k, dow[k]));
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    compare(0);
    compare(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    hready0 = 1'b1; hresp0 = 1'b0; hrdata0 = 32'hA5A5_0000; w0 = 2'b00;
    hready1 = 1'b1; hresp1 = 1'b0; hrdata1 = 32'h5A5A_0000; w1 = 3'b000;
    for (int m = 0; m < 2; m++) begin
      t0[m] = IDLE; a0[m] = 32'h0; b0[m] = 3'd0; wd0[m] = 32'hD000_0000 + 32'(m);
    end
    for (int m = 0; m < 3; m++) begin
      t1[m] = IDLE; a1[m] = 32'h0; b1[m] = 3'd0; wd1[m] = 32'hE000_0000 + 32'(m);
    end
    tick(); tick();
    settle();
    chk("rst.grant", 32'(gnt0), 32'h1);
    chk("rst.ready", 32'(rdy0), 32'h3);
    rst0 = 1'b0;
    tick();

    // single master INCR4 read at 0x1000
    for (int i = 0; i < 4; i++) begin
      t0[0] = (i == 0) ? NONSEQ : SEQ;
      a0[0] = 32'h1000 + 32'(4 * i);
      b0[0] = 3'b011;
      settle();
      chk("incr4.haddr", haddr0, 32'h1000 + 32'(4 * i));
      chk("incr4.ready0", 32'(rdy0[0]), 32'h1);
      tick();
    end
    t0[0] = IDLE; b0[0] = 3'd0;

    // master 1 takes the parked bus, then fixed priority back to 0
    t0[1] = NONSEQ; a0[1] = 32'h2000; w0 = 2'b10;
    settle(); chk("fp.stall1", 32'(rdy0), 32'h1);
    tick();
    settle(); chk("fp.grant1", 32'(gnt0), 32'h2); chk("fp.haddr1", haddr0, 32'h2000);
    tick();
    t0[1] = SEQ; a0[1] = 32'h2004;
    tick();
    t0[1] = IDLE; t0[0] = NONSEQ; a0[0] = 32'h3000;
    settle(); chk("fp.ready", 32'(rdy0), 32'h2);
    tick();
    settle(); chk("fp.grant0", 32'(gnt0), 32'h1);
    t0[0] = SEQ; a0[0] = 32'h3004; t0[1] = NONSEQ; a0[1] = 32'h2100;
    tick();
    t0[0] = SEQ; a0[0] = 32'h3008;
    settle(); chk("fp.hold", 32'(gnt0), 32'h1); chk("fp.stall", 32'(rdy0), 32'h1);
    tick();
    t0[0] = IDLE;
    tick();
    settle(); chk("fp.back1", 32'(gnt0), 32'h2); chk("fp.haddr2100", haddr0, 32'h2100);
    tick();

    // slave wait states block the handoff
    t0[1] = IDLE; t0[0] = NONSEQ; a0[0] = 32'h4000; w0 = 2'b00; hready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("ws.hold", 32'(gnt0), 32'h2);
      tick();
    end
    hready0 = 1'b1;
    tick();
    settle(); chk("ws.grant0", 32'(gnt0), 32'h1); chk("ws.haddr", haddr0, 32'h4000);

    // two-cycle ERROR on master 0's read
    tick();
    t0[0] = IDLE; hready0 = 1'b0; hresp0 = 1'b1;
    settle(); chk("err.c1", 32'(resp0), 32'h1);
    tick();
    hready0 = 1'b1;
    settle(); chk("err.c2", 32'(resp0), 32'h1);
    tick();
    hresp0 = 1'b0;

    // master 0 hogs the bus; master 1 starves
    for (int i = 0; i < 300; i++) begin
      t0[0] = (i == 0) ? NONSEQ : SEQ;
      a0[0] = 32'h5000 + 32'(4 * i);
      t0[1] = NONSEQ; a0[1] = 32'h6000;
      settle();
      if (i == 254) chk("starve.pre", 32'(stv0), 32'h0);
      if (i == 255) chk("starve.rise", 32'(stv0), 32'h2);
      tick();
    end
    t0[0] = IDLE;
    tick();
    settle(); chk("starve.grant", 32'(gnt0), 32'h2); chk("starve.held", 32'(stv0), 32'h2);
    t0[1] = SEQ; a0[1] = 32'h6004;
    tick();
    settle(); chk("starve.clear", 32'(stv0), 32'h0);

    // reset in the middle of master 1's burst
    t0[1] = SEQ; a0[1] = 32'h6008; rst0 = 1'b1;
    settle();
    chk("rst.htrans", 32'(htrans0), 32'h0);
    chk("rst.grant0", 32'(gnt0), 32'h1);
    chk("rst.ready11", 32'(rdy0), 32'h3);
    chk("rst.starve", 32'(stv0), 32'h0);
    tick();
    rst0 = 1'b0; t0[1] = IDLE;
    tick(); tick();

    // round-robin: each master issues one single then IDLE
    rst1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      for (int m = 0; m < 3; m++) begin
        t1[m] = ((i % 2 == 1) && (m == ((i - 1) / 2) % 3)) ? IDLE : NONSEQ;
        a1[m] = 32'h8000_0000 + 32'(m * 256 + i * 4);
      end
      settle();
      if (i == 2) chk("rr.g1", 32'(gnt1), 32'h2);
      if (i == 4) chk("rr.g2", 32'(gnt1), 32'h4);
      if (i == 6) chk("rr.g0", 32'(gnt1), 32'h1);
      if (i == 8) chk("rr.g1b", 32'(gnt1), 32'h2);
      if (i == 3) chk("rr.starve2", 32'(stv1), 32'h4);
      if (i == 5) chk("rr.starve0", 32'(stv1), 32'h1);
      tick();
    end
    for (int m = 0; m < 3; m++) t1[m] = IDLE;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
